// File: rtl/led_blink_engine.sv
// led_blink_engine
//   Timing and pattern core for the LED controller. Consumes the four AXI4-Lite
//   control registers (slv_reg0..3) and a per-register write strobe, and drives
//   the board LEDs either as a prescaled on/off blink of a pattern or as a
//   rotating shift of that pattern.
//
// Ports
//   ACLK           system clock, shared with the AXI slave
//   ARESETN        asynchronous active-low reset
//   ctrl_i         slv_reg0: [0] enable, [1] mode (0 blink, 1 shift), [2] invert
//   period_i       slv_reg1: ACLK cycles per prescaler tick (0 treated as 1)
//   duty_i         slv_reg2: [15:0] on_ticks, [31:16] off_ticks
//   pattern_i      slv_reg3: LED pattern, bits [NUM_LEDS-1:0] used
//   reg_wr_i       one-cycle pulse when the register file commits a write
//   reg_wr_addr_i  index of the register written with reg_wr_i
//   led_o          registered LED drive
//   tick_o         one-cycle prescaler tick pulse
//   state_o        FSM state: 0 IDLE, 1 ON, 2 OFF, 3 SHIFT
module led_blink_engine #(
  parameter int NUM_LEDS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pattern_i,
  input  logic                          reg_wr_i,
  input  logic [1:0]                    reg_wr_addr_i,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic                          tick_o,
  output logic [1:0]                    state_o
);

  localparam int W = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic [NUM_LEDS-1:0] shift_q, shift_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  // Rotate left by one; for a single LED the value simply holds.
  function automatic logic [NUM_LEDS-1:0] rotl1(input logic [NUM_LEDS-1:0] v);
    return (v << 1) | (v >> (NUM_LEDS - 1));
  endfunction

  logic                en, mode;
  logic [NUM_LEDS-1:0] inv_mask, pat;
  logic [15:0]         on_ticks, off_ticks;
  logic [W-1:0]        period_eff;
  logic                active, stop, wrap, wr_period, wr_pattern, tick_ev;
  logic                on_done, off_done, phase_done;
  logic                unused_bits;

  assign en         = ctrl_i[0];
  assign mode       = ctrl_i[1];
  assign inv_mask   = {NUM_LEDS{ctrl_i[2]}};
  assign pat        = pattern_i[NUM_LEDS-1:0];
  assign on_ticks   = duty_i[15:0];
  assign off_ticks  = duty_i[31:16];
  assign period_eff = (period_i == '0) ? W'(1) : period_i;
  assign unused_bits = ^{ctrl_i, pattern_i};

  assign active     = (state_q != S_IDLE);
  // Leaving a running mode: enable dropped or mode bit no longer matches the state.
  assign stop       = active && (!en || (mode != (state_q == S_SHIFT)));
  // >= rather than == so a period lowered below the current count wraps at once.
  assign wrap       = (cnt_q >= period_eff - W'(1));
  assign wr_period  = reg_wr_i && (reg_wr_addr_i == 2'd1);
  assign wr_pattern = reg_wr_i && (reg_wr_addr_i == 2'd3);
  // A period write restarts the prescaler and swallows a coincident tick.
  assign tick_ev    = active && !stop && !wr_period && wrap;
  // >= so that shrinking on/off_ticks mid-phase ends the phase on the next tick.
  assign on_done    = ({1'b0, tcnt_q} + 17'd1) >= {1'b0, on_ticks};
  assign off_done   = ({1'b0, tcnt_q} + 17'd1) >= {1'b0, off_ticks};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      tcnt_q  <= '0;
      shift_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      tcnt_q  <= tcnt_d;
      shift_q <= shift_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = mode ? S_SHIFT : ((on_ticks != '0) ? S_ON : S_OFF);
      S_ON: begin
        if (stop)                                          state_d = S_IDLE;
        else if (tick_ev && on_done && (off_ticks != '0))  state_d = S_OFF;
      end
      S_OFF: begin
        if (stop)                                          state_d = S_IDLE;
        else if (tick_ev && off_done && (on_ticks != '0))  state_d = S_ON;
      end
      S_SHIFT: if (stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = (!active || stop || wr_period || wrap) ? '0 : cnt_q + W'(1);
    tick_d     = tick_ev;

    phase_done = (state_q == S_ON) ? on_done : off_done;
    tcnt_d     = tcnt_q;
    if (!active || stop) begin
      tcnt_d = '0;
    end else if (tick_ev && (state_q != S_SHIFT)) begin
      tcnt_d = phase_done ? 16'd0 : tcnt_q + 16'd1;
    end

    shift_d = shift_q;
    if ((state_q == S_IDLE) && en && mode) begin
      shift_d = pat;
    end else if ((state_q == S_SHIFT) && !stop) begin
      // A pattern write wins over a rotate landing on the same edge.
      if (wr_pattern)   shift_d = pat;
      else if (tick_ev) shift_d = rotl1(shift_q);
    end

    case (state_d)
      S_ON:    led_d = pat ^ inv_mask;
      S_SHIFT: led_d = shift_d ^ inv_mask;
      default: led_d = inv_mask;
    endcase
  end

  assign led_o   = led_q;
  assign tick_o  = tick_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_led_blink_engine.sv
module tb_led_blink_engine;

  localparam int N = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic [31:0]   ctrl, period, duty, pattern;
  logic          reg_wr;
  logic [1:0]    reg_wr_addr;
  logic [N-1:0]  led;
  logic          tick;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase, prescaler count, ticks spent in phase,
  // shift pattern as (base, rotation amount).
  int          m_state, m_tcnt, m_rot;
  longint      m_cnt;
  logic [3:0]  m_base, m_led;
  logic        m_tick;

  led_blink_engine #(.NUM_LEDS(N), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ctrl_i(ctrl), .period_i(period),
    .duty_i(duty), .pattern_i(pattern), .reg_wr_i(reg_wr),
    .reg_wr_addr_i(reg_wr_addr), .led_o(led), .tick_o(tick), .state_o(state)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [3:0] rot_by(input logic [3:0] p, input int k);
    logic [7:0] w;
    w = {4'b0, p} << k;
    return w[3:0] | w[7:4];
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_tcnt = 0; m_rot = 0;
    m_base = '0; m_led = '0; m_tick = 1'b0;
  endtask

  task automatic model_edge();
    bit en, md, leaving, clr, ld, tk;
    logic [3:0] inv, pat;
    int on_t, off_t, len, other;
    longint pe;
    if (!ARESETN) begin model_reset(); return; end
    en = ctrl[0]; md = ctrl[1]; inv = ctrl[2] ? 4'hF : 4'h0;
    pat = pattern[3:0]; on_t = int'(duty[15:0]); off_t = int'(duty[31:16]);
    pe = (period == 0) ? 1 : longint'(period);
    clr = reg_wr && (reg_wr_addr == 2'd1);
    ld  = reg_wr && (reg_wr_addr == 2'd3);
    leaving = (m_state != 0) && (!en || (md != (m_state == 3)));
    tk = (m_state != 0) && !leaving && !clr && (m_cnt >= pe - 1);
    if (m_state == 0 || leaving || clr || tk) m_cnt = 0; else m_cnt++;
    if (m_state == 0) begin
      if (en && md)  begin m_state = 3; m_base = pat; m_rot = 0; end
      else if (en)   begin m_state = (on_t != 0) ? 1 : 2; m_tcnt = 0; end
    end else if (leaving) begin
      m_state = 0; m_tcnt = 0;
    end else if (m_state == 3) begin
      if (ld)      begin m_base = pat; m_rot = 0; end
      else if (tk) m_rot = (m_rot + 1) % N;
    end else if (tk) begin
      len   = (m_state == 1) ? on_t : off_t;
      other = (m_state == 1) ? off_t : on_t;
      if (m_tcnt + 1 >= len) begin
        m_tcnt = 0;
        if (other != 0) m_state = 3 - m_state;
      end else begin
        m_tcnt++;
      end
    end
    m_tick = tk;
    case (m_state)
      1:       m_led = pat ^ inv;
      3:       m_led = rot_by(m_base, m_rot) ^ inv;
      default: m_led = inv;
    endcase
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then settle; write strobes last exactly one edge.
  task automatic step();
    @(posedge ACLK);
    model_edge();
    #1;
    reg_wr = 1'b0;
  endtask

  task automatic test_reset();
    int ticks_seen;
    ctrl = 0; period = 0; duty = 0; pattern = 0; reg_wr = 0; reg_wr_addr = 0;
    #2 ARESETN = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({state, tick, led} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: got state=%0d tick=%0b led=%h required all 0", state, tick, led);
    end
    step(); step();
    ARESETN = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick) ticks_seen++;
      checks++;
      if ({state, tick, led} !== {m_state[1:0], m_tick, m_led}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got s=%0d t=%0b l=%h required s=%0d t=%0b l=%h",
                 i, state, tick, led, m_state, m_tick, m_led);
      end
    end
    checks++;
    if (ticks_seen != 0) begin
      errors++;
      $display("FAIL reset_no_tick: got %0d ticks required 0", ticks_seen);
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp_led;
    logic       exp_tick;
    period = 4; duty = 32'h0002_0003; pattern = 32'hA; ctrl = 32'h1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i < 20) begin
        exp_led  = (i < 12) ? 4'hA : 4'h0;
        exp_tick = (i > 0) && (i % 4 == 0);
        checks++;
        if (led !== exp_led || tick !== exp_tick) begin
          errors++;
          $display("FAIL blink_seq i=%0d: got led=%h tick=%0b required led=%h tick=%0b",
                   i, led, tick, exp_led, exp_tick);
        end
      end
      checks++;
      if ({state, tick, led} !== {m_state[1:0], m_tick, m_led}) begin
        errors++;
        $display("FAIL blink_model i=%0d: got s=%0d t=%0b l=%h required s=%0d t=%0b l=%h",
                 i, state, tick, led, m_state, m_tick, m_led);
      end
    end
    ctrl = 0;
    step();
  endtask

  task automatic test_shift();
    logic [3:0] exp_led;
    period = 2; pattern = 32'h1; ctrl = 32'h3;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_led = 4'h1 << ((i / 2) % 4);
      checks++;
      if (led !== exp_led || state !== 2'd3) begin
        errors++;
        $display("FAIL shift_seq i=%0d: got led=%h state=%0d required led=%h state=3",
                 i, led, state, exp_led);
      end
    end
    ctrl = 32'h7;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({state, tick, led} !== {m_state[1:0], m_tick, m_led}) begin
        errors++;
        $display("FAIL shift_invert i=%0d: got s=%0d t=%0b l=%h required s=%0d t=%0b l=%h",
                 i, state, tick, led, m_state, m_tick, m_led);
      end
    end
    ctrl = 32'h3;
  endtask

  task automatic wait_pre_tick(input string name);
    int n;
    n = 0;
    while (m_cnt != longint'(period) - 1 && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_wait: got no tick within 20 cycles required a tick", name);
    end
  endtask

  task automatic test_reload();
    period = 3;
    step(); step();
    wait_pre_tick("reload");
    pattern = 32'h3; reg_wr = 1'b1; reg_wr_addr = 2'd3;
    step();
    checks++;
    if (led !== 4'h3 || tick !== 1'b1 || led !== m_led) begin
      errors++;
      $display("FAIL reload_coincident: got led=%h tick=%0b required led=3 tick=1", led, tick);
    end
    wait_pre_tick("period_clr");
    reg_wr = 1'b1; reg_wr_addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tick !== (i == 3) || {state, tick, led} !== {m_state[1:0], m_tick, m_led}) begin
        errors++;
        $display("FAIL period_clr i=%0d: got tick=%0b led=%h required tick=%0b led=%h",
                 i, tick, led, (i == 3), m_led);
      end
    end
  endtask

  task automatic test_enable_mode();
    pattern = 32'h5; period = 3; duty = 32'h0004_0004; ctrl = 32'h1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (state !== 2'd1 || led !== 4'h5) begin
      errors++;
      $display("FAIL mode_to_blink: got state=%0d led=%h required state=1 led=5", state, led);
    end
    ctrl = 32'h0;
    step();
    checks++;
    if (state !== 2'd0 || led !== 4'h0) begin
      errors++;
      $display("FAIL enable_clear: got state=%0d led=%h required state=0 led=0", state, led);
    end
    ctrl = 32'h1;
    step(); step(); step();
    ctrl = 32'h3;
    step();
    checks++;
    if (state !== 2'd0 || state !== m_state[1:0]) begin
      errors++;
      $display("FAIL mode_toggle_idle: got state=%0d required 0", state);
    end
    step();
    checks++;
    if (state !== 2'd3 || led !== 4'h5) begin
      errors++;
      $display("FAIL mode_toggle_shift: got state=%0d led=%h required state=3 led=5", state, led);
    end
  endtask

  task automatic test_async_reset();
    step(); step(); step();
    #3 ARESETN = 1'b0;
    #1;
    checks++;
    if (led !== 4'h0 || state !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got led=%h state=%0d tick=%0b required 0 0 0", led, state, tick);
    end
    model_reset();
    step(); step();
    ARESETN = 1'b1;
    step();
    checks++;
    if (state !== 2'd3 || led !== pattern[3:0]) begin
      errors++;
      $display("FAIL reset_reentry: got state=%0d led=%h required state=3 led=%h",
               state, led, pattern[3:0]);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 31);
      case (r)
        0:       begin ctrl = $urandom_range(0, 7); reg_wr = 1; reg_wr_addr = 0; end
        1, 2:    begin period = $urandom_range(0, 6); reg_wr = 1; reg_wr_addr = 1; end
        3, 4:    begin
                   duty = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
                   reg_wr = 1; reg_wr_addr = 2;
                 end
        5, 6:    begin pattern = $urandom; reg_wr = 1; reg_wr_addr = 3; end
        7:       begin reg_wr = 1; reg_wr_addr = 2'($urandom_range(0, 3)); end
        default: ;
      endcase
      step();
      checks++;
      if ({state, tick, led} !== {m_state[1:0], m_tick, m_led}) begin
        errors++;
        $display("FAIL random i=%0d: got s=%0d t=%0b l=%h required s=%0d t=%0b l=%h",
                 i, state, tick, led, m_state, m_tick, m_led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_shift();
    test_reload();
    test_enable_mode();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_engine.md
Name: led_blink_engine

Overview:
Timing and pattern core that drives the board LEDs from the four AXI4-Lite control registers of the LED controller. It sits directly downstream of the S00_AXI slave register file and consumes slv_reg0..3 plus a per-register write strobe. It provides two modes: a prescaled on/off blink of a register-held pattern, and a rotating shift of that pattern.

Parameters:
NUM_LEDS, 4, number of LED outputs (1..32); the pattern uses bits [NUM_LEDS-1:0].
C_S_AXI_DATA_WIDTH, 32, width of each register input.

Ports:
ACLK  in  1  system clock, shared with the AXI slave.
ARESETN  in  1  asynchronous active-low reset.
ctrl_i  in  32  slv_reg0: bit0 enable, bit1 mode (0=blink, 1=shift), bit2 invert; other bits ignored.
period_i  in  32  slv_reg1: prescaler length in ACLK cycles per tick.
duty_i  in  32  slv_reg2: [15:0] on_ticks, [31:16] off_ticks.
pattern_i  in  32  slv_reg3: LED pattern.
reg_wr_i  in  1  one-cycle pulse when the register file commits a write.
reg_wr_addr_i  in  2  index of the register written with reg_wr_i.
led_o  out  NUM_LEDS  registered LED drive.
tick_o  out  1  one-cycle prescaler tick pulse.
state_o  out  2  current FSM state: 0 IDLE, 1 ON, 2 OFF, 3 SHIFT.

Behaviour:
- Reset (async assert, sync release): led_o=0, tick_o=0, state IDLE, prescaler=0, tick_cnt=0, shift_reg=0.
- All outputs are registered. Every decision uses inputs sampled at the same rising edge.
- Prescaler:
  - period_eff = max(period_i, 1).
  - In IDLE the counter is held at 0.
  - Otherwise it counts 0..period_eff-1. tick_o=1 for the cycle after the counter holds period_eff-1, then the counter wraps to 0.
  - If period_i is lowered below the current count, the counter wraps on the next cycle and asserts tick_o once.
  - reg_wr_i with addr 1 clears the counter. This clear has priority over a coincident tick; no tick is issued.
- FSM:
  - IDLE: led_o = {NUM_LEDS{invert}}.
    - enable=1 and mode=0: go to ON if on_ticks≠0, else OFF.
    - enable=1 and mode=1: go to SHIFT and load shift_reg=pattern_i[NUM_LEDS-1:0].
    - tick_cnt cleared on exit.
  - ON: led_o = pattern_i[NUM_LEDS-1:0] ^ {NUM_LEDS{invert}}.
    - On a tick with tick_cnt==on_ticks-1: tick_cnt←0, go to OFF if off_ticks≠0, else stay in ON.
    - On any other tick: tick_cnt++.
  - OFF: led_o = {NUM_LEDS{invert}}. Mirror of ON using off_ticks; returns to ON only if on_ticks≠0.
  - Degenerate duty: on_ticks=0 and off_ticks=0 stays in OFF (LEDs dark).
  - SHIFT: led_o = shift_reg ^ invert-mask.
    - On each tick, shift_reg rotates left by 1, MSB wrapping to bit0.
    - NUM_LEDS=1 holds its value.
  - From any non-IDLE state:
    - enable=0 forces IDLE on the next edge.
    - A change of the mode bit also forces IDLE; the block re-enters the new mode on the following edge (one-cycle restart).
- Entry latency: ctrl_i sampled with enable=1 at edge k gives state and led_o updated after edge k. The first tick arrives period_eff cycles later.
- Live updates:
  - ON/OFF re-read pattern_i, invert, on_ticks and off_ticks every cycle.
  - If on_ticks is reduced below tick_cnt+1 while in ON, the next tick ends the phase.
  - reg_wr_i with addr 3 in SHIFT reloads shift_reg from pattern_i, pre-empting a coincident rotate.
- reg_wr_i with addr 0 or 2 has no side effect beyond the new register value.
- Reset asserted mid-operation returns everything to reset values immediately.

Test Plan:
- Reset, then registers ctrl=0, period=0, duty=0, pattern=0 -> led_o=0, state_o=0, tick_o never asserts for 100 cycles.
- period=4, duty=0x0002_0003 (on 3 ticks, off 2), pattern=0xA, ctrl=1 -> led_o=0xA for 12 cycles, then 0x0 for 8 cycles, repeating; tick_o every 4 cycles.
- Shift: period=2, pattern=0x1, ctrl=0x3 -> led_o sequence 0x1,0x2,0x4,0x8,0x1, changing every 2 cycles. Set invert (ctrl=0x7) -> led_o shows the complemented sequence, e.g. 0xE,0xD,...
- Pattern write with reg_wr_addr_i=3 coincident with a tick in SHIFT (pattern 0x3) -> led_o=0x3, no rotate that tick. Period write coincident with a tick -> no tick_o, counter restarts at 0.
- Clear enable mid-ON -> state_o=0 and led_o=0 one edge later. Toggle the mode bit while enabled -> one cycle in IDLE, then SHIFT loaded with the current pattern.
- Assert ARESETN low asynchronously mid-SHIFT -> led_o=0 and state_o=0 without waiting for an ACLK edge. After release with ctrl still 0x3 -> SHIFT re-entered on the first edge.
